// File: rtl/binary_to_bcd_sequential.sv
// -----------------------------------------------------------------------------
// binary_to_bcd_sequential
//
// Iterative Double-Dabble binary-to-BCD converter. A single add-3/shift step
// datapath is reused once per clock, so an N-bit operand takes N cycles
// instead of an N-deep combinational chain.
//
// Handshakes (both sides): a transfer happens on a rising clock edge where
// valid && ready are both high. The producer holds valid (and data) until the
// transfer; the converter raises input_ready only in IDLE and holds
// output_valid/output_bcd stable in DONE until output_ready is seen.
//
// Ports
//   clock         rising-edge clock
//   reset         synchronous, active-high
//   input_valid   operand valid
//   input_ready   converter idle and able to accept an operand
//   input_binary  unsigned operand, sampled only on the accepting edge
//   output_valid  result valid (state DONE)
//   output_ready  consumer accepts the result
//   output_bcd    packed BCD result, digit 0 in bits [3:0]
//   busy          conversion in progress (state CONVERT)
// -----------------------------------------------------------------------------

// Decimal digits needed for a w-bit unsigned value: floor(w*log10(2))+1,
// with log10(2) approximated as 1233/4096.
`ifndef BINARY_TO_BCD_WIDTH
`define BINARY_TO_BCD_WIDTH(w) (((((w) * 1233) >> 12)) + 1)
`endif

module binary_to_bcd_sequential #(
   parameter int WIDTH_BINARY = 8,
   parameter int WIDTH_BCD    = `BINARY_TO_BCD_WIDTH(WIDTH_BINARY) * 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    input_valid,
   output logic                    input_ready,
   input  logic [WIDTH_BINARY-1:0] input_binary,
   output logic                    output_valid,
   input  logic                    output_ready,
   output logic [WIDTH_BCD-1:0]    output_bcd,
   output logic                    busy
);

   localparam int CW = $clog2(WIDTH_BINARY + 1);
   localparam int SW = WIDTH_BCD + WIDTH_BINARY;
   localparam int ND = WIDTH_BCD / 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [SW-1:0]         scratch_q, scratch_d;
   logic [CW-1:0]         count_q, count_d;
   logic [WIDTH_BCD-1:0]  bcd_q, bcd_d;

   logic [SW-1:0]         adjusted;
   logic [SW-1:0]         stepped;

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (input_valid) state_d = ST_CONVERT;
         end
         ST_CONVERT: begin
            if (count_q == CW'(1)) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (output_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;  // illegal encoding recovers to IDLE
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      input_ready  = 1'b0;
      output_valid = 1'b0;
      busy         = 1'b0;
      case (state_q)
         ST_IDLE:    input_ready  = 1'b1;
         ST_CONVERT: busy         = 1'b1;
         ST_DONE:    output_valid = 1'b1;
         default: begin
            input_ready  = 1'b0;
            output_valid = 1'b0;
            busy         = 1'b0;
         end
      endcase
   end

   assign output_bcd = bcd_q;

   // ---------------------------------------------------------------- step datapath
   // Digits >= 5 get +3 (carry out of the nibble is dropped), then the whole
   // scratch shifts left by one with a zero fill. Digits above WIDTH_BCD are
   // simply never represented, which yields the result mod 10^ND.
   always_comb begin
      adjusted = scratch_q;
      for (int i = 0; i < ND; i++) begin
         if (scratch_q[WIDTH_BINARY + 4*i +: 4] >= 4'd5) begin
            adjusted[WIDTH_BINARY + 4*i +: 4] = scratch_q[WIDTH_BINARY + 4*i +: 4] + 4'd3;
         end
      end
      stepped = {adjusted[SW-2:0], 1'b0};
   end

   always_comb begin
      scratch_d = scratch_q;
      count_d   = count_q;
      bcd_d     = bcd_q;
      case (state_q)
         ST_IDLE: begin
            if (input_valid) begin
               scratch_d = {{WIDTH_BCD{1'b0}}, input_binary};
               count_d   = CW'(WIDTH_BINARY);
            end
         end
         ST_CONVERT: begin
            scratch_d = stepped;
            count_d   = count_q - CW'(1);
            if (count_q == CW'(1)) bcd_d = stepped[SW-1 -: WIDTH_BCD];
         end
         default: begin
            scratch_d = scratch_q;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         scratch_q <= '0;
         count_q   <= '0;
         bcd_q     <= '0;
      end else begin
         scratch_q <= scratch_d;
         count_q   <= count_d;
         bcd_q     <= bcd_d;
      end
   end

endmodule

// File: tb/tb_binary_to_bcd_sequential.sv
// -----------------------------------------------------------------------------
// Bench for binary_to_bcd_sequential: 8-bit (default and truncated BCD width),
// 16-bit and 1-bit instances. Inputs change 1 time unit after the rising edge
// and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_binary_to_bcd_sequential;

   // ------------------------------------------------------------ clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;

   // 8-bit default and 8-bit with 2-digit result share stimulus
   logic        iv8 = 1'b0, or8 = 1'b1;
   logic [7:0]  ib8 = '0;
   logic        ir8, ov8, busy8;
   logic [11:0] bcd8;
   logic        ir8t, ov8t, busy8t;
   logic [7:0]  bcd8t;

   logic        iv16 = 1'b0, or16 = 1'b1;
   logic [15:0] ib16 = '0;
   logic        ir16, ov16, busy16;
   logic [19:0] bcd16;

   logic        iv1 = 1'b0, or1 = 1'b1;
   logic [0:0]  ib1 = '0;
   logic        ir1, ov1, busy1;
   logic [3:0]  bcd1;

   binary_to_bcd_sequential #(.WIDTH_BINARY(8)) dut8 (
      .clock(clk), .reset(rst), .input_valid(iv8), .input_ready(ir8),
      .input_binary(ib8), .output_valid(ov8), .output_ready(or8),
      .output_bcd(bcd8), .busy(busy8));

   binary_to_bcd_sequential #(.WIDTH_BINARY(8), .WIDTH_BCD(8)) dut8t (
      .clock(clk), .reset(rst), .input_valid(iv8), .input_ready(ir8t),
      .input_binary(ib8), .output_valid(ov8t), .output_ready(or8),
      .output_bcd(bcd8t), .busy(busy8t));

   binary_to_bcd_sequential #(.WIDTH_BINARY(16)) dut16 (
      .clock(clk), .reset(rst), .input_valid(iv16), .input_ready(ir16),
      .input_binary(ib16), .output_valid(ov16), .output_ready(or16),
      .output_bcd(bcd16), .busy(busy16));

   binary_to_bcd_sequential #(.WIDTH_BINARY(1)) dut1 (
      .clock(clk), .reset(rst), .input_valid(iv1), .input_ready(ir1),
      .input_binary(ib1), .output_valid(ov1), .output_ready(or1),
      .output_bcd(bcd1), .busy(busy1));

   // ------------------------------------------------------------ reference model
   // Plain decimal digit extraction, nd digits, packed digit 0 lowest.
   function automatic logic [31:0] to_bcd(input int unsigned v, input int nd);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < nd; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------ 8-bit driver
   task automatic conv8(input logic [7:0] val, input bit hold_iv, output int lat);
      int guard;
      guard = 0;
      while (!ir8 && guard < 50) begin tick(); guard++; end
      iv8 = 1'b1;
      ib8 = val;
      tick();                                  // accepting edge
      if (!hold_iv) iv8 = 1'b0;
      check("busy8_after_accept", {31'd0, busy8}, 32'd1);
      check("ir8_after_accept", {31'd0, ir8}, 32'd0);
      lat = 0;
      while (!ov8 && lat < 50) begin
         if (hold_iv) ib8 = 8'($urandom);
         tick();
         lat++;
      end
      iv8 = 1'b0;
   endtask

   typedef struct {
      logic [7:0]  bin;
      logic [11:0] bcd;
   } vec_t;

   vec_t tbl[7];

   // ------------------------------------------------------------ scoreboard (16-bit)
   logic [19:0] exp_q[$];

   initial begin
      int lat;
      int guard;
      logic [19:0] e;

      tbl[0] = '{8'd0,   12'h000};
      tbl[1] = '{8'd9,   12'h009};
      tbl[2] = '{8'd100, 12'h100};
      tbl[3] = '{8'd255, 12'h255};
      tbl[4] = '{8'd99,  12'h099};
      tbl[5] = '{8'd10,  12'h010};
      tbl[6] = '{8'd199, 12'h199};

      // ---------------- reset state
      repeat (2) tick();
      rst = 1'b0;
      check("rst_ir8",   {31'd0, ir8},   32'd1);
      check("rst_ov8",   {31'd0, ov8},   32'd0);
      check("rst_busy8", {31'd0, busy8}, 32'd0);
      check("rst_bcd8",  {20'd0, bcd8},  32'd0);
      check("rst_ir16",  {31'd0, ir16},  32'd1);
      check("rst_bcd16", {12'd0, bcd16}, 32'd0);

      // ---------------- table vectors, consumer always ready
      or8 = 1'b1;
      for (int i = 0; i < 7; i++) begin
         conv8(tbl[i].bin, 1'b0, lat);
         check("tbl_latency", lat, 32'd8);
         check("tbl_ov8", {31'd0, ov8}, 32'd1);
         check("tbl_bcd8", {20'd0, bcd8}, {20'd0, tbl[i].bcd});
         check("tbl_bcd8_trunc", {24'd0, bcd8t}, {24'd0, tbl[i].bcd[7:0]});
         tick();
         check("tbl_back_idle_ir8", {31'd0, ir8}, 32'd1);
         check("tbl_back_idle_ov8", {31'd0, ov8}, 32'd0);
      end

      // ---------------- 137 with consumer stalled for 20 cycles
      or8 = 1'b0;
      conv8(8'd137, 1'b0, lat);
      check("stall_latency", lat, 32'd8);
      for (int i = 0; i < 20; i++) begin
         tick();
         check("stall_ov8",  {31'd0, ov8},  32'd1);
         check("stall_bcd8", {20'd0, bcd8}, 32'h137);
         check("stall_ir8",  {31'd0, ir8},  32'd0);
      end
      or8 = 1'b1;
      tick();
      check("stall_release_ov8", {31'd0, ov8}, 32'd0);
      check("stall_release_ir8", {31'd0, ir8}, 32'd1);
      check("stall_keeps_bcd8", {20'd0, bcd8}, 32'h137);

      // ---------------- reset during conversion of 200
      iv8 = 1'b1;
      ib8 = 8'd200;
      tick();
      iv8 = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_ir8",   {31'd0, ir8},   32'd1);
      check("abort_ov8",   {31'd0, ov8},   32'd0);
      check("abort_busy8", {31'd0, busy8}, 32'd0);
      check("abort_bcd8",  {20'd0, bcd8},  32'd0);
      conv8(8'd42, 1'b0, lat);
      check("after_abort_latency", lat, 32'd8);
      check("after_abort_bcd8", {20'd0, bcd8}, 32'h042);
      tick();

      // ---------------- input_valid held high with changing data
      conv8(8'd77, 1'b1, lat);
      check("hold_iv_latency", lat, 32'd8);
      check("hold_iv_bcd8", {20'd0, bcd8}, 32'h077);
      tick();
      check("hold_iv_idle_ir8", {31'd0, ir8}, 32'd1);

      // ---------------- 1-bit operand
      for (int b = 0; b < 2; b++) begin
         iv1 = 1'b1;
         ib1 = 1'(b);
         tick();
         iv1 = 1'b0;
         check("w1_busy", {31'd0, busy1}, 32'd1);
         check("w1_ov_early", {31'd0, ov1}, 32'd0);
         tick();
         check("w1_ov", {31'd0, ov1}, 32'd1);
         check("w1_bcd", {28'd0, bcd1}, b);
         tick();
         check("w1_idle", {31'd0, ir1}, 32'd1);
      end

      // ---------------- 16-bit: 65535 then 1000 random operands
      for (int n = 0; n < 1001; n++) begin
         logic [15:0] v;
         v = (n == 0) ? 16'd65535 : 16'($urandom_range(0, 65535));
         guard = 0;
         while (!ir16 && guard < 50) begin tick(); guard++; end
         or16 = 1'b0;
         iv16 = 1'b1;
         ib16 = v;
         exp_q.push_back(20'(to_bcd(v, 5)));
         tick();
         iv16 = 1'b0;
         lat = 0;
         while (!ov16 && lat < 60) begin tick(); lat++; end
         check("w16_latency", lat, 32'd16);
         e = exp_q.pop_front();
         check("w16_bcd", {12'd0, bcd16}, {12'd0, e});
         repeat ($urandom_range(0, 2)) begin
            tick();
            check("w16_held", {12'd0, bcd16}, {12'd0, e});
         end
         or16 = 1'b1;
         tick();
         check("w16_release", {31'd0, ov16}, 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
